// File: rtl/iterative_branch_comparator.sv
// Multi-cycle branch-condition comparator: walks the operands one CHUNK per
// cycle from the MSB chunk and stops at the first differing chunk. Also keeps
// a small condition-flag register that results can be written into and read
// back through flag-read op codes.
module iterative_branch_comparator #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter int NUM_FLAGS = 4
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [3:0]           Operation,
  input  logic [WIDTH-1:0]     Operand1,
  input  logic [WIDTH-1:0]     Operand2,
  input  logic                 FlagWrite,
  input  logic [2:0]           FlagDest,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Result,
  output logic [NUM_FLAGS-1:0] Flags
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [2:0]             r_op;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_fw;
  logic [2:0]             r_fdest;
  logic [CW-1:0]          r_cnt;
  logic                   r_result;
  logic [NUM_FLAGS-1:0]   r_flags;

  logic [CHUNK-1:0]       w_ca;
  logic [CHUNK-1:0]       w_cb;
  logic                   w_top;
  logic                   w_signed;
  logic                   w_ceq;
  logic                   w_cgt;
  logic                   w_term;
  logic                   w_cmp_res;
  logic                   w_flag_res;

  // Chunk evaluation. Operands are shifted left each cycle so the chunk under
  // test is always the top CHUNK bits; since the run stops at the first
  // differing chunk, that chunk alone decides eq/gt for the whole word.
  always_comb begin
    w_ca     = r_a[WIDTH-1 -: CHUNK];
    w_cb     = r_b[WIDTH-1 -: CHUNK];
    w_top    = (r_cnt == CW'(NCHUNK - 1));
    w_signed = (r_op == 3'd4) || (r_op == 3'd5) || (r_op == 3'd7);
    if (w_top && w_signed) begin
      w_ca[CHUNK-1] = ~w_ca[CHUNK-1];
      w_cb[CHUNK-1] = ~w_cb[CHUNK-1];
    end
    w_ceq  = (w_ca == w_cb);
    w_cgt  = (w_ca > w_cb);
    w_term = !w_ceq || (r_cnt == '0);
    case (r_op)
      3'd0:       w_cmp_res = w_ceq;
      3'd1:       w_cmp_res = !w_ceq;
      3'd2, 3'd4: w_cmp_res = w_cgt || w_ceq;
      3'd3, 3'd5: w_cmp_res = w_cgt;
      default:    w_cmp_res = !w_cgt && !w_ceq;
    endcase
  end

  // Flag-read result for the op presented at the input; codes past NUM_FLAGS read 0.
  always_comb begin
    w_flag_res = 1'b0;
    for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
      if (Operation == 4'(8 + i)) w_flag_res = r_flags[i];
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (r_state)
      S_IDLE: begin
        InReady = 1'b1;
        if (InValid) w_next = Operation[3] ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_term) w_next = S_DONE;
      end
      S_DONE: begin
        OutValid = 1'b1;
        if (OutReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, chunk stepping, result and flag register updates.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_fw     <= 1'b0;
      r_fdest  <= '0;
      r_cnt    <= '0;
      r_result <= 1'b0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            r_op    <= Operation[2:0];
            r_a     <= Operand1;
            r_b     <= Operand2;
            r_fw    <= FlagWrite;
            r_fdest <= FlagDest;
            r_cnt   <= CW'(NCHUNK - 1);
            if (Operation[3]) begin
              r_result <= w_flag_res;
              if (FlagWrite) begin
                for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
                  if (FlagDest == 3'(i)) r_flags[i] <= w_flag_res;
                end
              end
            end
          end
        end
        S_RUN: begin
          if (w_term) begin
            r_result <= w_cmp_res;
            if (r_fw) begin
              for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
                if (r_fdest == 3'(i)) r_flags[i] <= w_cmp_res;
              end
            end
          end else begin
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Result = r_result;
  assign Flags  = r_flags;

endmodule
